// File: rtl/ahb_params_pkg.sv
// AHB-Lite encodings, slave FSM state type and the byte-lane decode shared by the memory slave.
package ahb_params_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Little-endian lanes; sizes above word fall through to a full-word write.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << lo;
      HSIZE_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slv_mem_array.sv
// Word-organised storage: byte-enabled synchronous write, asynchronous read on the same index.
module ahb_slv_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (be_i[b]) begin
          mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite SRAM slave with a fixed wait-state count per OKAY data phase.
// Define AHB_SLV_ERR_EN to raise ERROR on out-of-range, oversize or misaligned accesses.
module ahb_slave_mem
  import ahb_params_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned IdxW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DepthW = ADDR_WIDTH'(MEM_DEPTH);

  slv_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  dp_q, dp_d;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [1:0]            lo_q;
  logic [IdxW-1:0]       idx_q;
  logic                  addr_ok, accept, illegal, ready, resp, we;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [IdxW-1:0]       idx_a;
  logic [DATA_WIDTH-1:0] rdata;

  // Only IDLE/ERR2 present HREADYOUT=1, so the registered transfer is held otherwise.
  assign addr_ok   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
  assign accept    = HSEL & HREADY & HTRANS[1] & addr_ok;
  assign word_addr = HADDR >> 2;
  assign idx_a     = IdxW'(word_addr % DepthW);

`ifdef AHB_SLV_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] ByteLimit = ADDR_WIDTH'(MEM_DEPTH * 4);
  assign illegal = (HADDR >= ByteLimit) || (HSIZE > HSIZE_WORD) ||
                   ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                   ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dp_q    <= 1'b0;
      write_q <= 1'b0;
      size_q  <= '0;
      lo_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      if (accept) begin
        write_q <= HWRITE;
        size_q  <= HSIZE;
        lo_q    <= HADDR[1:0];
        idx_q   <= idx_a;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    ready   = 1'b1;
    resp    = HRESP_OKAY;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        resp    = (state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        state_d = ST_IDLE;
        dp_d    = 1'b0;
        if (accept) begin
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            dp_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
      ST_WAIT: begin
        ready = 1'b0;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERR1: begin
        ready   = 1'b0;
        resp    = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completing data-phase edge is the only edge where dp_q is set in ST_IDLE.
  assign we = dp_q & write_q & (state_q == ST_IDLE);

  ahb_slv_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IdxW)
  ) u_array (
    .clk_i   (HCLK),
    .we_i    (we),
    .be_i    (byte_en(size_q, lo_q)),
    .idx_i   (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (rdata)
  );

  assign HRDATA    = (dp_q && !write_q) ? rdata : '0;
  assign HREADYOUT = ready;
  assign HRESP     = resp;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench: two slaves (1 and 0 wait states) share one bus; a monitor checks each data phase.
module tb_ahb_slave_mem;
  import ahb_params_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel1, hsel0, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] rd1, rd0, hrdata;
  logic        rdy1, rdy0, resp1, resp0, hready, hresp;

  always #5 hclk = ~hclk;

  // Idle slaves drive zero data and OKAY, so OR/AND stand in for the response mux.
  assign hready = rdy1 & rdy0;
  assign hrdata = rd1 | rd0;
  assign hresp  = resp1 | resp0;

  ahb_slave_mem #(.WAIT_STATES(1)) u_ws1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1)
  );

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  typedef struct {
    int          waits;
    logic        resp;
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   in_dp = 1'b0;
  int   wcnt = 0;
  exp_t cur;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: counts HREADYOUT-low cycles, then checks the completing data phase.
  always @(negedge hclk) begin
    if (!hresetn) begin
      in_dp = 1'b0;
      sb.delete();
    end else begin
      if (in_dp) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
          in_dp = 1'b0;
        end else if (!hready) begin
          wcnt++;
          check({sb[0].name, "_wait_resp"}, {31'd0, hresp}, {31'd0, sb[0].resp});
          if (wcnt > 20) begin
            check({sb[0].name, "_ready_timeout"}, {31'd0, hready}, 32'd1);
            void'(sb.pop_front());
            in_dp = 1'b0;
          end
        end else begin
          cur = sb.pop_front();
          check({cur.name, "_waits"}, 32'(wcnt), 32'(cur.waits));
          check({cur.name, "_resp"}, {31'd0, hresp}, {31'd0, cur.resp});
          check({cur.name, "_rdata"}, hrdata, cur.rdata);
          in_dp = 1'b0;
        end
      end
      if ((hsel1 | hsel0) && hready && htrans[1]) begin
        in_dp = 1'b1;
        wcnt  = 0;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge hclk);
    while (!hready && n < 30) begin
      @(negedge hclk);
      n++;
    end
    if (!hready) check("bus_ready_timeout", {31'd0, hready}, 32'd1);
  endtask

  // Issue one NONSEQ transfer to slave s (1: u_ws1, 0: u_ws0); returns just after acceptance.
  task automatic xfer(input bit s, input logic [31:0] a, input bit w, input logic [2:0] sz,
                      input logic [31:0] wd, input int waits, input bit resp,
                      input logic [31:0] rdat, input string nm);
    exp_t e;
    e.waits = waits;
    e.resp  = resp;
    e.rdata = rdat;
    e.name  = nm;
    hsel1  = s;
    hsel0  = !s;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = w;
    hsize  = sz;
    sb.push_back(e);
    wait_ready();
    @(posedge hclk);
    #1;
    hwdata = wd;
  endtask

  task automatic idle();
    hsel1  = 1'b0;
    hsel0  = 1'b0;
    htrans = HTRANS_IDLE;
    wait_ready();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn = 1'b0;
    hsel1 = 1'b0; hsel0 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
    hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
    #1;
    check("rst_ready1", {31'd0, rdy1}, 32'd1);
    check("rst_ready0", {31'd0, rdy0}, 32'd1);
    check("rst_resp1", {31'd0, resp1}, 32'd0);
    check("rst_resp0", {31'd0, resp0}, 32'd0);
    check("rst_rdata1", rd1, 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // 1: word write/read with one wait state each
    xfer(1, 32'h10, 1, HSIZE_WORD, 32'hDEADBEEF, 1, 0, 32'h0, "t1_wr");
    xfer(1, 32'h10, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hDEADBEEF, "t1_rd");
    idle();

    // 2: byte and half lane merges
    xfer(1, 32'h10, 1, HSIZE_WORD, 32'h11223344, 1, 0, 32'h0, "t2_wr_word");
    xfer(1, 32'h13, 1, HSIZE_BYTE, 32'hAA000000, 1, 0, 32'h0, "t2_wr_b3");
    xfer(1, 32'h10, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hAA223344, "t2_rd_b3");
    xfer(1, 32'h11, 1, HSIZE_BYTE, 32'h00009900, 1, 0, 32'h0, "t2_wr_b1");
    xfer(1, 32'h10, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hAA229944, "t2_rd_b1");
    xfer(1, 32'h14, 1, HSIZE_WORD, 32'h55667788, 1, 0, 32'h0, "t2_wr_word2");
    xfer(1, 32'h16, 1, HSIZE_HALF, 32'hBEEF0000, 1, 0, 32'h0, "t2_wr_half");
    xfer(1, 32'h14, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hBEEF7788, "t2_rd_half");
    idle();

    // 3: zero wait states, back-to-back
    xfer(0, 32'h0, 1, HSIZE_WORD, 32'hA5A50001, 0, 0, 32'h0, "t3_wr0");
    xfer(0, 32'h4, 1, HSIZE_WORD, 32'h00005A5A, 0, 0, 32'h0, "t3_wr4");
    xfer(0, 32'h0, 0, HSIZE_WORD, 32'h0, 0, 0, 32'hA5A50001, "t3_rd0");
    xfer(0, 32'h4, 0, HSIZE_WORD, 32'h0, 0, 0, 32'h00005A5A, "t3_rd4");
    idle();

    // 4: misaligned word read at 0x402
    xfer(1, 32'h0, 1, HSIZE_WORD, 32'hCAFEF00D, 1, 0, 32'h0, "t4_wr0");
`ifdef AHB_SLV_ERR_EN
    xfer(1, 32'h402, 0, HSIZE_WORD, 32'h0, 1, 1, 32'h0, "t4_rd_err");
`else
    xfer(1, 32'h402, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hCAFEF00D, "t4_rd_wrap");
`endif

    // 5: write at MEM_DEPTH*4, then IDLE in the following cycle
`ifdef AHB_SLV_ERR_EN
    xfer(1, 32'h400, 1, HSIZE_WORD, 32'h12345678, 1, 1, 32'h0, "t5_wr_err");
    idle();
    check("t5_idle_ready", {31'd0, hready}, 32'd1);
    check("t5_idle_resp", {31'd0, hresp}, 32'd0);
    xfer(1, 32'h0, 0, HSIZE_WORD, 32'h0, 1, 0, 32'hCAFEF00D, "t5_rd_unchanged");
`else
    xfer(1, 32'h400, 1, HSIZE_WORD, 32'h12345678, 1, 0, 32'h0, "t5_wr_wrap");
    idle();
    check("t5_idle_ready", {31'd0, hready}, 32'd1);
    check("t5_idle_resp", {31'd0, hresp}, 32'd0);
    xfer(1, 32'h0, 0, HSIZE_WORD, 32'h0, 1, 0, 32'h12345678, "t5_rd_wrapped");
`endif
    idle();

    // 6: reset while a write sits in its wait state
    xfer(1, 32'h20, 1, HSIZE_WORD, 32'h11111111, 1, 0, 32'h0, "t6_wr_old");
    idle();
    xfer(1, 32'h20, 1, HSIZE_WORD, 32'h22222222, 1, 0, 32'h0, "t6_wr_abort");
    #1;
    check("t6_pre_wait", {31'd0, rdy1}, 32'd0);
    hresetn = 1'b0;
    hsel1 = 1'b0;
    htrans = HTRANS_IDLE;
    #1;
    check("t6_rst_ready", {31'd0, rdy1}, 32'd1);
    check("t6_rst_resp", {31'd0, resp1}, 32'd0);
    check("t6_rst_rdata", rd1, 32'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    xfer(1, 32'h20, 0, HSIZE_WORD, 32'h0, 1, 0, 32'h11111111, "t6_rd_old");
    idle();

    repeat (3) @(posedge hclk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
